// File: rtl/banked_register_file.sv
// Multi-bank register file: two combinational read ports, one write port with
// same-cycle bypass, and a one-entry-per-cycle clear engine (INIT after reset, CLEAR on request).
module banked_register_file #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 6,
  parameter int NBANKS = 2,
  parameter int BANK_W = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [BANK_W-1:0] rs_bank,
  input  logic [ADDR_W-1:0] rd,
  input  logic [BANK_W-1:0] rd_bank,
  input  logic [DATA_W-1:0] write_data,
  input  logic              we,
  input  logic              clr_req,
  input  logic [BANK_W-1:0] clr_bank,
  output logic [DATA_W-1:0] regA_o,
  output logic [DATA_W-1:0] regB_o,
  output logic              busy,
  output logic              wr_drop
);

  typedef enum logic [1:0] {INIT, IDLE, CLEAR} state_t;

  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);
  localparam logic [BANK_W:0]   NBANKS_L = (BANK_W + 1)'(NBANKS);
  localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(DEPTH - 1);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] cnt, cnt_nx;
  logic [BANK_W-1:0] tgt, tgt_nx;
  logic [DATA_W-1:0] mem [NBANKS][DEPTH];

  logic wr_ok;
  logic clr_ok;
  logic rd_bank_in;
  logic rs_bank_in;
  logic rs_blank;

  always_comb begin
    rd_bank_in = {1'b0, rd_bank} < NBANKS_L;
    rs_bank_in = {1'b0, rs_bank} < NBANKS_L;
    wr_ok      = we && ({1'b0, rd} < DEPTH_L) && rd_bank_in &&
                 ((state == IDLE) || ((state == CLEAR) && (rd_bank != tgt)));
    clr_ok     = clr_req && ({1'b0, clr_bank} < NBANKS_L);
    // The bank being swept reads as zero for the whole sweep, not just cleared entries.
    rs_blank   = (state == INIT) || ((state == CLEAR) && (rs_bank == tgt));
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    tgt_nx   = tgt;
    case (state)
      INIT, CLEAR: begin
        cnt_nx = cnt + ADDR_W'(1);
        if (cnt == LAST) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      end
      IDLE: begin
        if (clr_ok) begin
          state_nx = CLEAR;
          tgt_nx   = clr_bank;
          cnt_nx   = '0;
        end
      end
      default: begin
        state_nx = INIT;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= INIT;
      cnt     <= '0;
      tgt     <= '0;
      wr_drop <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      tgt     <= tgt_nx;
      wr_drop <= we && !wr_ok;
    end
  end

  // Array has no reset; its contents are defined by the INIT sweep.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      for (int unsigned b = 0; b < NBANKS; b++) begin
        mem[BANK_W'(b)][cnt] <= '0;
      end
    end else if (state == CLEAR) begin
      mem[tgt][cnt] <= '0;
    end
    if (wr_ok) begin
      mem[rd_bank][rd] <= write_data;
    end
  end

  always_comb begin
    regA_o = '0;
    if (({1'b0, rs1} < DEPTH_L) && rs_bank_in && !rs_blank) begin
      if (wr_ok && (rd_bank == rs_bank) && (rd == rs1)) begin
        regA_o = write_data;
      end else begin
        regA_o = mem[rs_bank][rs1];
      end
    end
  end

  always_comb begin
    regB_o = '0;
    if (({1'b0, rs2} < DEPTH_L) && rs_bank_in && !rs_blank) begin
      if (wr_ok && (rd_bank == rs_bank) && (rd == rs2)) begin
        regB_o = write_data;
      end else begin
        regB_o = mem[rs_bank][rs2];
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_banked_register_file.sv
// Directed bench for banked_register_file: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_banked_register_file;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] rs1 = '0, rs2 = '0, rd = '0;
  logic       rs_bank = 1'b0, rd_bank = 1'b0, clr_bank = 1'b0;
  logic [7:0] write_data = '0;
  logic       we = 1'b0, clr_req = 1'b0;
  logic [7:0] regA_o, regB_o;
  logic       busy, wr_drop;

  banked_register_file #(
    .DATA_W(8), .ADDR_W(3), .DEPTH(6), .NBANKS(2), .BANK_W(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rs1(rs1), .rs2(rs2), .rs_bank(rs_bank),
    .rd(rd), .rd_bank(rd_bank), .write_data(write_data), .we(we),
    .clr_req(clr_req), .clr_bank(clr_bank), .regA_o(regA_o), .regB_o(regB_o),
    .busy(busy), .wr_drop(wr_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    int         kind;  // 0 regA, 1 regB, 2 busy, 3 wr_drop
    logic [7:0] val;
    string      name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  logic [7:0] e0 [6] = '{8'h5A, 8'h00, 8'hA5, 8'h00, 8'h77, 8'h00};
  logic [7:0] e1 [6] = '{8'h00, 8'h00, 8'h00, 8'h42, 8'h00, 8'h00};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : monitor
    int         i;
    logic [7:0] act;
    i = 0;
    while (i < q.size()) begin
      if (q[i].cyc <= cyc) begin
        case (q[i].kind)
          0:       act = regA_o;
          1:       act = regB_o;
          2:       act = {7'b0, busy};
          default: act = {7'b0, wr_drop};
        endcase
        tests++;
        if (q[i].cyc < cyc) begin
          fails++;
          $display("FAIL %s: check for cycle %0d missed (now cycle %0d)", q[i].name, q[i].cyc, cyc);
        end else if (act !== q[i].val) begin
          fails++;
          $display("FAIL %s cycle %0d: got %02h expected %02h", q[i].name, cyc, act, q[i].val);
        end
        q.delete(i);
      end else begin
        i++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks pending", q.size());
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
    we      = 1'b0;
    clr_req = 1'b0;
  endtask

  task automatic wr(input logic b, input logic [2:0] a, input logic [7:0] d);
    we = 1'b1; rd_bank = b; rd = a; write_data = d;
  endtask

  task automatic sel(input logic b, input logic [2:0] a1, input logic [2:0] a2);
    rs_bank = b; rs1 = a1; rs2 = a2;
  endtask

  task automatic push_exp(input int kind, input logic [7:0] v, input string nm, input int dly);
    exp_t e;
    e.cyc = cyc + dly; e.kind = kind; e.val = v; e.name = nm;
    q.push_back(e);
  endtask

  task automatic rd2(input logic [7:0] a, input logic [7:0] b, input string nm);
    push_exp(0, a, {nm, "_A"}, 0);
    push_exp(1, b, {nm, "_B"}, 0);
  endtask

  task automatic bz(input logic v, input string nm);
    push_exp(2, {7'b0, v}, nm, 0);
  endtask

  task automatic dr(input logic v, input string nm);
    push_exp(3, {7'b0, v}, nm, 1);
  endtask

  initial begin
    // Reset held
    step(); step();
    sel(1'b0, 3'd2, 3'd3);
    bz(1'b1, "rst_busy"); rd2(8'h00, 8'h00, "rst_rd"); push_exp(3, 8'h00, "rst_drop", 0);

    // Release; a write during INIT is dropped
    step();
    rst_n = 1'b1;
    wr(1'b0, 3'd1, 8'hFF);
    bz(1'b1, "init_busy0"); rd2(8'h00, 8'h00, "init_rd0"); dr(1'b1, "init_drop");
    for (int i = 1; i < 6; i++) begin
      step();
      bz(1'b1, $sformatf("init_busy%0d", i)); rd2(8'h00, 8'h00, $sformatf("init_rd%0d", i));
      dr(1'b0, $sformatf("init_nodrop%0d", i));
    end
    step();
    bz(1'b0, "init_done");

    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 6; i++) begin
        step();
        sel(1'(b), 3'(i), 3'(5 - i));
        rd2(8'h00, 8'h00, $sformatf("zero_b%0d_%0d", b, i)); bz(1'b0, "idle_busy");
      end
    end

    // Basic writes, both banks
    step(); wr(1'b0, 3'd2, 8'hA5); sel(1'b0, 3'd0, 3'd1); rd2(8'h00, 8'h00, "w0_rd"); dr(1'b0, "w0_drop");
    step(); wr(1'b1, 3'd2, 8'h3C); sel(1'b0, 3'd2, 3'd2); rd2(8'hA5, 8'hA5, "b0r2"); dr(1'b0, "w1_drop");
    step(); sel(1'b1, 3'd2, 3'd2); rd2(8'h3C, 8'h3C, "b1r2");

    // Bypass
    step(); wr(1'b0, 3'd4, 8'h77); sel(1'b0, 3'd4, 3'd5); rd2(8'h77, 8'h00, "bypass");
    step(); sel(1'b0, 3'd4, 3'd2); rd2(8'h77, 8'hA5, "bypass_stored");

    // Out-of-range writes and reads
    step(); wr(1'b0, 3'd6, 8'hEE); sel(1'b0, 3'd6, 3'd7); rd2(8'h00, 8'h00, "oor6"); dr(1'b1, "oor6_drop");
    step(); wr(1'b0, 3'd7, 8'hEE); sel(1'b0, 3'd7, 3'd6); rd2(8'h00, 8'h00, "oor7"); dr(1'b1, "oor7_drop");
    step(); sel(1'b0, 3'd2, 3'd4); rd2(8'hA5, 8'h77, "oor_unchanged"); dr(1'b0, "oor_end");

    // Fill bank 1 with 0x10..0x15
    for (int i = 0; i < 6; i++) begin
      step();
      wr(1'b1, 3'(i), 8'(16 + i));
      if (i == 0) begin
        sel(1'b1, 3'd0, 3'd5); rd2(8'h10, 8'h00, "fill0");
      end else begin
        sel(1'b1, 3'(i), 3'(i - 1)); rd2(8'(16 + i), 8'(15 + i), $sformatf("fill%0d", i));
      end
      dr(1'b0, $sformatf("fill_drop%0d", i));
    end

    // Clear bank 1
    step();
    clr_req = 1'b1; clr_bank = 1'b1;
    sel(1'b1, 3'd0, 3'd5); rd2(8'h10, 8'h15, "clr_req_rd"); bz(1'b0, "clr_req_busy");
    for (int j = 1; j <= 6; j++) begin
      step();
      sel(1'b1, 3'(j - 1), 3'd5);
      rd2(8'h00, 8'h00, $sformatf("clr_rd%0d", j)); bz(1'b1, $sformatf("clr_busy%0d", j));
      if (j == 2) begin wr(1'b0, 3'd0, 8'h5A); dr(1'b0, "clr_other_bank"); end
      if (j == 3) begin wr(1'b1, 3'd1, 8'h99); dr(1'b1, "clr_same_bank"); end
      if (j == 4) begin clr_req = 1'b1; clr_bank = 1'b0; dr(1'b0, "clr_after_drop"); end
      if (j == 6) begin wr(1'b1, 3'd0, 8'h88); dr(1'b1, "clr_last_drop"); end
    end
    step();
    wr(1'b1, 3'd3, 8'h42); sel(1'b1, 3'd3, 3'd0);
    rd2(8'h42, 8'h00, "post_clr_write"); bz(1'b0, "clr_done"); dr(1'b0, "post_clr_drop");

    for (int i = 0; i < 6; i++) begin
      step(); sel(1'b1, 3'(i), 3'(5 - i)); rd2(e1[i], e1[5 - i], $sformatf("after_b1_%0d", i));
    end
    for (int i = 0; i < 6; i++) begin
      step(); sel(1'b0, 3'(i), 3'(5 - i)); rd2(e0[i], e0[5 - i], $sformatf("after_b0_%0d", i));
    end

    // Write plus clear in the same cycle, then reset mid-sweep
    step();
    wr(1'b0, 3'd5, 8'h33); clr_req = 1'b1; clr_bank = 1'b0;
    sel(1'b0, 3'd5, 3'd4); rd2(8'h33, 8'h77, "wr_clr_same"); bz(1'b0, "wr_clr_busy");
    step(); sel(1'b0, 3'd5, 3'd0); rd2(8'h00, 8'h00, "sweep0_rd"); bz(1'b1, "sweep0_busy1");
    step(); bz(1'b1, "sweep0_busy2");
    step();
    rst_n = 1'b0;
    bz(1'b1, "midrst_busy"); rd2(8'h00, 8'h00, "midrst_rd"); push_exp(3, 8'h00, "midrst_drop", 0);
    step();
    rst_n = 1'b1;
    bz(1'b1, "reinit_busy0");
    for (int i = 1; i < 6; i++) begin
      step(); sel(1'b1, 3'd3, 3'd2);
      bz(1'b1, $sformatf("reinit_busy%0d", i)); rd2(8'h00, 8'h00, $sformatf("reinit_rd%0d", i));
    end
    step();
    bz(1'b0, "reinit_done");
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 6; i++) begin
        step(); sel(1'(b), 3'(i), 3'(5 - i));
        rd2(8'h00, 8'h00, $sformatf("reinit_zero_b%0d_%0d", b, i));
      end
    end

    step(); step(); step();
    @(negedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
